// File: rtl/rename_regfile_mp.sv
// Architectural register file with per-register ROB rename tags.
// Define RENAME_RF_COMMIT_BYPASS_EN to forward same-cycle commits to reads.
module rename_regfile_mp #(
  parameter  int XLEN  = 32,
  parameter  int NREG  = 32,
  parameter  int TAG_W = 4,
  parameter  int NREAD = 2,
  localparam int AW    = $clog2(NREG)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rdy,
  input  logic                  flush,
  input  logic [NREAD*AW-1:0]   rs_idx,
  output logic [NREAD-1:0]      rs_ready,
  output logic [NREAD*XLEN-1:0] rs_val,
  input  logic                  disp_en,
  input  logic [AW-1:0]         disp_rd,
  input  logic [TAG_W-1:0]      disp_tag,
  input  logic                  cmt_en,
  input  logic [AW-1:0]         cmt_rd,
  input  logic [TAG_W-1:0]      cmt_tag,
  input  logic [XLEN-1:0]       cmt_val,
  output logic [AW:0]           busy_cnt
);

  logic [XLEN-1:0]  val_q [NREG];
  logic [TAG_W-1:0] tag_q [NREG];
  logic [NREG-1:0]  busy_q;
  logic [AW:0]      cnt_q;

  logic disp_wr;
  logic cmt_wr;
  logic cmt_clr;
  logic cnt_inc;
  logic cnt_dec;

  // Decode which rename/value updates take effect this cycle.
  always_comb begin
    disp_wr = disp_en && (disp_rd != '0);
    cmt_wr  = cmt_en && (cmt_rd != '0);
    cmt_clr = cmt_wr && busy_q[cmt_rd] &&
              (tag_q[cmt_rd] == cmt_tag);
    cnt_inc = disp_wr && !busy_q[disp_rd];
    cnt_dec = cmt_clr &&
              !(disp_wr && (disp_rd == cmt_rd));
  end

  // Register state: values, busy bits, tags and the busy count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        val_q[i] <= '0;
        tag_q[i] <= '0;
      end
      busy_q <= '0;
      cnt_q  <= '0;
    end else if (rdy) begin
      if (cmt_wr)
        val_q[cmt_rd] <= cmt_val;
      if (flush) begin
        for (int i = 0; i < NREG; i++)
          tag_q[i] <= '0;
        busy_q <= '0;
        cnt_q  <= '0;
      end else begin
        if (cmt_clr)
          busy_q[cmt_rd] <= 1'b0;
        // Dispatch is applied last so it wins on a shared rd.
        if (disp_wr) begin
          busy_q[disp_rd] <= 1'b1;
          tag_q[disp_rd]  <= disp_tag;
        end
        cnt_q <= cnt_q + {{AW{1'b0}}, cnt_inc}
                       - {{AW{1'b0}}, cnt_dec};
      end
    end
  end

  assign busy_cnt = cnt_q;

  // Independent combinational read ports: value or pending tag.
  always_comb begin
    logic [AW-1:0] idx;
    idx      = '0;
    rs_ready = '0;
    rs_val   = '0;
    for (int k = 0; k < NREAD; k++) begin
      idx = rs_idx[k*AW +: AW];
      if (idx == '0) begin
        rs_ready[k]           = 1'b1;
        rs_val[k*XLEN +: XLEN] = '0;
      end else if (!busy_q[idx]) begin
        rs_ready[k]           = 1'b1;
        rs_val[k*XLEN +: XLEN] = val_q[idx];
      end else begin
        rs_ready[k]           = 1'b0;
        rs_val[k*XLEN +: XLEN] = XLEN'(tag_q[idx]);
      end
`ifdef RENAME_RF_COMMIT_BYPASS_EN
      if (cmt_en && rdy && !flush &&
          (idx != '0) && (cmt_rd == idx) &&
          busy_q[idx] && (tag_q[idx] == cmt_tag)) begin
        rs_ready[k]           = 1'b1;
        rs_val[k*XLEN +: XLEN] = cmt_val;
      end
`endif
    end
  end

endmodule

// File: tb/tb_rename_regfile_mp.sv
// Directed self-checking bench for rename_regfile_mp.
// Vector table plus hand sequences for bypass and count saturation.
module tb_rename_regfile_mp;

  logic        clk = 1'b0;
  logic        rst_n, rdy, flush;
  logic [9:0]  rs_idx;
  logic [1:0]  rs_ready;
  logic [63:0] rs_val;
  logic        disp_en, cmt_en;
  logic [4:0]  disp_rd, cmt_rd;
  logic [3:0]  disp_tag, cmt_tag;
  logic [31:0] cmt_val;
  logic [5:0]  busy_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rename_regfile_mp dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .flush(flush),
    .rs_idx(rs_idx), .rs_ready(rs_ready), .rs_val(rs_val),
    .disp_en(disp_en), .disp_rd(disp_rd), .disp_tag(disp_tag),
    .cmt_en(cmt_en), .cmt_rd(cmt_rd), .cmt_tag(cmt_tag),
    .cmt_val(cmt_val), .busy_cnt(busy_cnt)
  );

  typedef struct {
    logic        rst_n, rdy, flush;
    logic        de;
    logic [4:0]  drd;
    logic [3:0]  dtag;
    logic        ce;
    logic [4:0]  crd;
    logic [3:0]  ctag;
    logic [31:0] cval;
    logic [4:0]  r0, r1;
    logic        er0;
    logic [31:0] ev0;
    logic        er1;
    logic [31:0] ev1;
    logic [5:0]  ecnt;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle();
    rst_n = 1'b1; rdy = 1'b1; flush = 1'b0;
    disp_en = 1'b0; cmt_en = 1'b0;
    disp_rd = '0; disp_tag = '0;
    cmt_rd = '0; cmt_tag = '0; cmt_val = '0;
  endtask

  task automatic chk_ports(input string nm,
                           input logic er0, input logic [31:0] ev0,
                           input logic er1, input logic [31:0] ev1);
    chk({nm, " rdy0"}, {31'd0, rs_ready[0]}, {31'd0, er0});
    chk({nm, " val0"}, rs_val[31:0], ev0);
    chk({nm, " rdy1"}, {31'd0, rs_ready[1]}, {31'd0, er1});
    chk({nm, " val1"}, rs_val[63:32], ev1);
  endtask

  initial begin
    //          rst  rdy  fl   de    drd    dtag   ce    crd    ctag   cval           r0     r1     er0   ev0            er1   ev1            cnt
    vq.push_back('{1'b0,1'b1,1'b0,1'b0,5'd0, 4'd0, 1'b0,5'd0, 4'd0, 32'h0,         5'd5, 5'd0, 1'b1,32'h0,         1'b1,32'h0,         6'd0});
    vq.push_back('{1'b1,1'b1,1'b0,1'b0,5'd0, 4'd0, 1'b1,5'd0, 4'd0, 32'hDEAD,      5'd0, 5'd5, 1'b1,32'h0,         1'b1,32'h0,         6'd0});
    vq.push_back('{1'b1,1'b1,1'b0,1'b1,5'd3, 4'd7, 1'b0,5'd0, 4'd0, 32'h0,         5'd3, 5'd0, 1'b0,32'h7,         1'b1,32'h0,         6'd1});
    vq.push_back('{1'b1,1'b1,1'b0,1'b0,5'd0, 4'd0, 1'b1,5'd3, 4'd7, 32'h1234,      5'd3, 5'd3, 1'b1,32'h1234,      1'b1,32'h1234,      6'd0});
    vq.push_back('{1'b1,1'b1,1'b0,1'b1,5'd4, 4'd2, 1'b0,5'd0, 4'd0, 32'h0,         5'd4, 5'd3, 1'b0,32'h2,         1'b1,32'h1234,      6'd1});
    vq.push_back('{1'b1,1'b1,1'b0,1'b1,5'd4, 4'd9, 1'b0,5'd0, 4'd0, 32'h0,         5'd4, 5'd0, 1'b0,32'h9,         1'b1,32'h0,         6'd1});
    vq.push_back('{1'b1,1'b1,1'b0,1'b0,5'd0, 4'd0, 1'b1,5'd4, 4'd2, 32'hAA,        5'd4, 5'd0, 1'b0,32'h9,         1'b1,32'h0,         6'd1});
    vq.push_back('{1'b1,1'b1,1'b0,1'b0,5'd0, 4'd0, 1'b1,5'd4, 4'd9, 32'hBB,        5'd4, 5'd0, 1'b1,32'hBB,        1'b1,32'h0,         6'd0});
    vq.push_back('{1'b1,1'b1,1'b0,1'b1,5'd6, 4'd3, 1'b0,5'd0, 4'd0, 32'h0,         5'd6, 5'd4, 1'b0,32'h3,         1'b1,32'hBB,        6'd1});
    vq.push_back('{1'b1,1'b1,1'b0,1'b1,5'd6, 4'd5, 1'b1,5'd6, 4'd3, 32'h55,        5'd6, 5'd4, 1'b0,32'h5,         1'b1,32'hBB,        6'd1});
    vq.push_back('{1'b1,1'b1,1'b1,1'b1,5'd7, 4'd1, 1'b1,5'd6, 4'd5, 32'h66,        5'd6, 5'd7, 1'b1,32'h66,        1'b1,32'h0,         6'd0});
    vq.push_back('{1'b1,1'b1,1'b0,1'b1,5'd9, 4'd2, 1'b0,5'd0, 4'd0, 32'h0,         5'd9, 5'd8, 1'b0,32'h2,         1'b1,32'h0,         6'd1});
    vq.push_back('{1'b1,1'b0,1'b1,1'b1,5'd8, 4'd1, 1'b1,5'd9, 4'd2, 32'h77,        5'd8, 5'd9, 1'b1,32'h0,         1'b0,32'h2,         6'd1});
    vq.push_back('{1'b0,1'b0,1'b0,1'b0,5'd0, 4'd0, 1'b0,5'd0, 4'd0, 32'h0,         5'd6, 5'd9, 1'b1,32'h0,         1'b1,32'h0,         6'd0});
    vq.push_back('{1'b1,1'b1,1'b0,1'b1,5'd1, 4'd3, 1'b0,5'd0, 4'd0, 32'h0,         5'd1, 5'd0, 1'b0,32'h3,         1'b1,32'h0,         6'd1});
    vq.push_back('{1'b1,1'b1,1'b0,1'b1,5'd2, 4'd4, 1'b1,5'd1, 4'd3, 32'h11,        5'd1, 5'd2, 1'b1,32'h11,        1'b0,32'h4,         6'd1});
    vq.push_back('{1'b1,1'b1,1'b0,1'b1,5'd0, 4'd5, 1'b0,5'd0, 4'd0, 32'h0,         5'd0, 5'd2, 1'b1,32'h0,         1'b0,32'h4,         6'd1});
    vq.push_back('{1'b1,1'b1,1'b0,1'b1,5'd5, 4'd6, 1'b1,5'd5, 4'd6, 32'h99,        5'd5, 5'd2, 1'b0,32'h6,         1'b0,32'h4,         6'd2});
    vq.push_back('{1'b1,1'b1,1'b1,1'b0,5'd0, 4'd0, 1'b0,5'd0, 4'd0, 32'h0,         5'd5, 5'd2, 1'b1,32'h99,        1'b1,32'h0,         6'd0});

    idle();
    rs_idx = '0;
    @(negedge clk);

    foreach (vq[i]) begin
      string nm;
      nm = $sformatf("v%0d", i);
      rst_n = vq[i].rst_n; rdy = vq[i].rdy; flush = vq[i].flush;
      disp_en = vq[i].de; disp_rd = vq[i].drd; disp_tag = vq[i].dtag;
      cmt_en = vq[i].ce; cmt_rd = vq[i].crd; cmt_tag = vq[i].ctag;
      cmt_val = vq[i].cval;
      rs_idx = {vq[i].r1, vq[i].r0};
      @(posedge clk);
      #1 idle();
      #1;
      chk_ports(nm, vq[i].er0, vq[i].ev0, vq[i].er1, vq[i].ev1);
      chk({nm, " cnt"}, {26'd0, busy_cnt}, {26'd0, vq[i].ecnt});
    end

    // Commit forwarding on a busy register, same cycle and next cycle.
    disp_en = 1'b1; disp_rd = 5'd10; disp_tag = 4'd4;
    @(posedge clk);
    #1 idle();
    cmt_en = 1'b1; cmt_rd = 5'd10; cmt_tag = 4'd4; cmt_val = 32'hCAFE;
    rs_idx = {5'd11, 5'd10};
    #1;
`ifdef RENAME_RF_COMMIT_BYPASS_EN
    chk_ports("byp_same", 1'b1, 32'hCAFE, 1'b1, 32'h0);
`else
    chk_ports("byp_same", 1'b0, 32'h4, 1'b1, 32'h0);
`endif
    @(posedge clk);
    #1 idle();
    #1;
    chk_ports("byp_next", 1'b1, 32'hCAFE, 1'b1, 32'h0);
    chk("byp_cnt", {26'd0, busy_cnt}, 32'd0);

    // Rename every non-zero register; count saturates at NREG-1.
    for (int r = 1; r < 32; r++) begin
      disp_en = 1'b1; disp_rd = 5'(r); disp_tag = 4'(r);
      @(posedge clk);
      #1;
    end
    idle();
    #1;
    chk("full_cnt", {26'd0, busy_cnt}, 32'd31);
    rs_idx = {5'd31, 5'd17};
    #1;
    chk_ports("full_rd", 1'b0, 32'h1, 1'b0, 32'hF);
    disp_en = 1'b1; disp_rd = 5'd31; disp_tag = 4'd2;
    @(posedge clk);
    #1 idle();
    #1;
    chk("redisp_cnt", {26'd0, busy_cnt}, 32'd31);
    chk("redisp_tag", rs_val[63:32], 32'h2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rename_regfile_mp.md
Name: rename_regfile_mp

Overview:
- Parametrised architectural register file with per-register rename tags for the out-of-order core.
- Sits between decode/dispatch, the ROB and the reservation stations:
  - Dispatch claims a destination register by tagging it with a ROB entry.
  - ROB commit retires values into it.
  - Issue reads NREAD source operands per cycle, each as a value or as a ROB tag.
- Adds several features over the previous two-port version:
  - Configurable width, depth, tag width and read-port count.
  - A global flush for mispredict recovery.
  - A live count of renamed registers.
  - An optional same-cycle commit bypass.

Parameters:
- XLEN, 32, data width of each register.
- NREG, 32, number of architectural registers. Must be a power of two, ≥2. Register 0 is hardwired to zero.
- TAG_W, 4, ROB tag width. Must satisfy TAG_W ≤ XLEN.
- NREAD, 2, number of combinational read ports.
- AW, $clog2(NREG), derived register index width. Not overridable.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- rdy  in  1  global ready; when low, all state holds
- flush  in  1  mispredict recovery; drop every rename
- rs_idx  in  NREAD*AW  flattened read indices; port k uses bits [k*AW +: AW]
- rs_ready  out  NREAD  1 = value valid, 0 = operand pending on a ROB tag
- rs_val  out  NREAD*XLEN  register value if ready, else the tag zero-extended to XLEN
- disp_en  in  1  dispatch claims a destination register
- disp_rd  in  AW  destination register index
- disp_tag  in  TAG_W  ROB tag of the dispatching instruction
- cmt_en  in  1  ROB commit writes a register
- cmt_rd  in  AW  committed register index
- cmt_tag  in  TAG_W  ROB tag of the committing entry
- cmt_val  in  XLEN  committed value
- busy_cnt  out  AW+1  number of registers currently renamed

Behaviour:
- State per register: val[XLEN], busy (1 = renamed), tag[TAG_W]. Plus the busy_cnt register.
- Reset: when rst_n is low at posedge clk:
  - all val = 0, busy = 0, tag = 0, busy_cnt = 0.
  - Reset overrides rdy, flush, dispatch and commit.
- rdy low, rst_n high: no state change of any kind; flush, dispatch and commit are all ignored.
- All updates below occur at posedge clk with rst_n=1 and rdy=1.
- Read ports: purely combinational, zero latency, all ports independent.
  - rs_idx=0: ready=1, val=0.
  - otherwise busy=0: ready=1, val=val[r].
  - otherwise busy=1: ready=0, val={0, tag[r]}.
  - After reset, all ports read ready=1, val=0.
- Register 0: dispatch or commit to index 0 changes no state and does not affect busy_cnt.
- Dispatch only (disp_en, rd≠0): busy[rd] <= 1, tag[rd] <= disp_tag. Re-dispatch to an already busy register overwrites the tag.
- Commit only (cmt_en, rd≠0):
  - val[rd] <= cmt_val, unconditionally.
  - busy[rd] <= 0 only if busy[rd]=1 and tag[rd]==cmt_tag. On a stale tag, busy and tag are untouched.
- Dispatch and commit, same rd≠0:
  - val <= cmt_val, busy <= 1, tag <= disp_tag.
  - Dispatch wins rename state regardless of tag match.
- Dispatch and commit, different rd: both apply independently.
- Flush:
  - All busy <= 0, all tag <= 0, busy_cnt <= 0.
  - A same-cycle commit still writes val.
  - A same-cycle dispatch is discarded.
- busy_cnt tracks the popcount of busy, updated in the same cycle as busy:
  - +1 when dispatch targets a rd≠0 register whose busy is 0.
  - −1 when a commit clears busy, excluding the case where the same rd is also dispatched that cycle.
  - Both may apply in one cycle (net 0).
  - Never exceeds NREG−1.
- Registered state is updated only at posedge clk; no combinational path exists from disp_* to rs_*.

Optional Feature:
- Macro: RENAME_RF_COMMIT_BYPASS_EN
- Defined: for each read port, a same-cycle commit matching a busy register is forwarded.
  - Condition: cmt_en=1, rdy=1, flush=0, cmt_rd==rs_idx≠0, busy=1 and tag==cmt_tag.
  - Response: rs_ready=1, rs_val=cmt_val in that cycle.
- Undefined: rs_* reflect registered state only. A committed operand becomes ready one cycle later. No cmt_* → rs_* combinational path.

Test Plan:
- Reset then read x5, x0 on both ports → ready=1/1, val=0/0, busy_cnt=0. Commit x0 val 0xDEAD → x0 still reads 0.
- Dispatch x3 tag 7; next cycle read x3 → ready=0, val=0x7, busy_cnt=1. Commit x3 tag 7 val 0x1234 → next cycle ready=1, val=0x1234, busy_cnt=0.
- Stale commit: dispatch x4 tag 2, then dispatch x4 tag 9, then commit x4 tag 2 val 0xAA → x4 still ready=0, val=0x9, busy_cnt=1. Commit tag 9 val 0xBB → ready=1, val=0xBB, busy_cnt=0.
- Same-cycle dispatch x6 tag 5 + commit x6 tag 3 (x6 busy tag 3) val 0x55 → x6 ready=0, val=0x5, busy_cnt unchanged. Then flush with commit x6 tag 5 val 0x66 → x6 ready=1, val=0x66, busy_cnt=0.
- rdy=0 with dispatch x8 tag 1 and flush → no change; rst_n=0 during rdy=0 → all cleared next cycle.
- With RENAME_RF_COMMIT_BYPASS_EN: x10 busy tag 4; commit x10 tag 4 val 0xCAFE while reading x10 → same cycle ready=1, val=0xCAFE. Without the macro → ready=0, val=0x4 that cycle; ready=1, val=0xCAFE next cycle.
